// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard unit: a shift scoreboard of in-flight load destinations
// compared against the decode-stage source operands.

module lhs_slot_match #(
    parameter int REG_AW = 5
) (
    input  logic              v_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    output logic              rs_hit_o,
    output logic              rt_hit_o
);
    assign rs_hit_o = v_i && (dst_i == rs_i);
    assign rt_hit_o = v_i && (dst_i == rt_i);
endmodule

module load_hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int OPC_W    = 6,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iss_valid,
    input  logic [OPC_W-1:0]    iss_opcode,
    input  logic [REG_AW-1:0]   iss_rdef,
    input  logic                flush,
    input  logic                dec_valid,
    input  logic [REG_AW-1:0]   dec_rs,
    input  logic [REG_AW-1:0]   dec_rt,
    input  logic                dec_use_rs,
    input  logic                dec_use_rt,
    output logic                stall,
    output logic [1:0]          hazard_src,
    output logic [LOAD_LAT-1:0] pending,
    output logic [CNT_W-1:0]    stall_cnt
);
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
        $fatal(1, "load_hazard_scoreboard: LOAD_LAT must be in 1..7");
    end

    logic                             is_load;
    logic                             cap;
    logic [LOAD_LAT-1:0]              v_q, v_d;
    logic [LOAD_LAT-1:0][REG_AW-1:0]  dst_q, dst_d;
    logic [LOAD_LAT-1:0]              rs_hit, rt_hit;
    logic                             rs_match, rt_match;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             unused_opc;

    assign is_load    = (iss_opcode[OPC_W-1 -: 3] == 3'b100);
    assign unused_opc = ^iss_opcode[OPC_W-4:0];
    // $zero loads are never tracked, so a slot can only hold a real destination
    assign cap        = iss_valid && is_load && !flush && (iss_rdef != '0);

    always_comb begin
        v_d   = '0;
        dst_d = dst_q;
        for (int k = 0; k < LOAD_LAT - 1; k++) begin
            v_d[k]   = v_q[k+1];
            dst_d[k] = dst_q[k+1];
        end
        v_d[LOAD_LAT-1]   = cap;
        dst_d[LOAD_LAT-1] = iss_rdef;
    end

    for (genvar g = 0; g < LOAD_LAT; g++) begin : g_slot
        lhs_slot_match #(.REG_AW(REG_AW)) u_match (
            .v_i     (v_q[g]),
            .dst_i   (dst_q[g]),
            .rs_i    (dec_rs),
            .rt_i    (dec_rt),
            .rs_hit_o(rs_hit[g]),
            .rt_hit_o(rt_hit[g])
        );
    end

    assign rs_match   = dec_use_rs && (dec_rs != '0) && (|rs_hit);
    assign rt_match   = dec_use_rt && (dec_rt != '0) && (|rt_hit);
    assign stall      = dec_valid && !flush && (rs_match || rt_match);
    assign hazard_src = stall ? {rt_match, rs_match} : 2'b00;
    assign pending    = v_q;
    assign stall_cnt  = cnt_q;

    // Saturate rather than wrap so long-running profiles stay monotonic
    assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            dst_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_load_hazard_scoreboard.sv
// Directed scoreboard bench for load_hazard_scoreboard across several
// LOAD_LAT / CNT_W configurations sharing one stimulus bus.

module tb_load_hazard_scoreboard;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] ALU = 6'b000000;

    logic       clk;
    logic       reset;
    logic       iss_valid;
    logic [5:0] iss_opcode;
    logic [4:0] iss_rdef;
    logic       flush;
    logic       dec_valid;
    logic [4:0] dec_rs, dec_rt;
    logic       dec_use_rs, dec_use_rt;

    logic        st1, st2, st3, st4;
    logic [1:0]  hs1, hs2, hs3, hs4;
    logic [0:0]  p1;
    logic [1:0]  p2;
    logic [2:0]  p3;
    logic [0:0]  p4;
    logic [15:0] c1, c2, c3;
    logic [3:0]  c4;

    load_hazard_scoreboard #(.LOAD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
        .iss_rdef(iss_rdef), .flush(flush), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .stall(st1), .hazard_src(hs1), .pending(p1), .stall_cnt(c1));
    load_hazard_scoreboard #(.LOAD_LAT(2)) u2 (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
        .iss_rdef(iss_rdef), .flush(flush), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .stall(st2), .hazard_src(hs2), .pending(p2), .stall_cnt(c2));
    load_hazard_scoreboard #(.LOAD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
        .iss_rdef(iss_rdef), .flush(flush), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .stall(st3), .hazard_src(hs3), .pending(p3), .stall_cnt(c3));
    load_hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(4)) u4 (
        .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
        .iss_rdef(iss_rdef), .flush(flush), .dec_valid(dec_valid), .dec_rs(dec_rs),
        .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .stall(st4), .hazard_src(hs4), .pending(p4), .stall_cnt(c4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [26:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // {stall, hazard_src, pending zero-extended to 8, stall_cnt zero-extended to 16}
    function automatic logic [26:0] obs(input int id);
        case (id)
            1:       return {st1, hs1, {7'b0, p1}, c1};
            2:       return {st2, hs2, {6'b0, p2}, c2};
            3:       return {st3, hs3, {5'b0, p3}, c3};
            default: return {st4, hs4, {7'b0, p4}, {12'b0, c4}};
        endcase
    endfunction

    task automatic push(input int id, input logic est, input logic [1:0] ehs,
                        input logic [7:0] ep, input logic [15:0] ec, input string tag);
        exp_t e;
        e.id  = id;
        e.val = {est, ehs, ep, ec};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [26:0] o;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=none expected=entry");
        end else begin
            e = sb.pop_front();
            o = obs(e.id);
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s dut=%0d observed=%h expected=%h", e.tag, e.id, o, e.val);
            end
        end
    endtask

    task automatic set_in(input logic iv, input logic [5:0] opc, input logic [4:0] rdef,
                          input logic fl, input logic dv, input logic [4:0] rs,
                          input logic [4:0] rt, input logic urs, input logic urt);
        iss_valid  = iv;
        iss_opcode = opc;
        iss_rdef   = rdef;
        flush      = fl;
        dec_valid  = dv;
        dec_rs     = rs;
        dec_rt     = rt;
        dec_use_rs = urs;
        dec_use_rt = urt;
    endtask

    // One pipeline cycle: drive, expect, check at the falling edge, advance
    task automatic cyc(input int id, input logic iv, input logic [5:0] opc,
                       input logic [4:0] rdef, input logic fl, input logic dv,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic est, input logic [1:0] ehs,
                       input logic [7:0] ep, input logic [15:0] ec, input string tag);
        set_in(iv, opc, rdef, fl, dv, rs, rt, urs, urt);
        push(id, est, ehs, ep, ec, tag);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, ALU, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, ALU, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int d = 1; d <= 4; d++) begin
            push(d, 0, 2'b00, 8'd0, 16'd0, "reset_state");
            pop_check();
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // LOAD_LAT=1 single-cycle stall on rs, then a non-load issue
        cyc(1, 1, LW, 8, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "A_issue");
        cyc(1, 0, LW, 0, 0, 1, 8, 0, 1, 0,  1, 2'b01, 1, 0, "A_stall");
        cyc(1, 0, LW, 0, 0, 1, 8, 0, 1, 0,  0, 2'b00, 0, 1, "A_release");
        cyc(1, 1, ALU, 8, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, "A_alu_issue");
        cyc(1, 0, LW, 0, 0, 1, 8, 0, 1, 0,  0, 2'b00, 0, 1, "A_alu_nohaz");

        // LOAD_LAT=3 stall on rt, rs=$0 is ignored
        do_reset();
        cyc(3, 1, LW, 5, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "B_issue");
        cyc(3, 0, LW, 0, 0, 1, 0, 5, 1, 1,  1, 2'b10, 4, 0, "B_s1");
        cyc(3, 0, LW, 0, 0, 1, 0, 5, 1, 1,  1, 2'b10, 2, 1, "B_s2");
        cyc(3, 0, LW, 0, 0, 1, 0, 5, 1, 1,  1, 2'b10, 1, 2, "B_s3");
        cyc(3, 0, LW, 0, 0, 1, 0, 5, 1, 1,  0, 2'b00, 0, 3, "B_done");

        // $zero, unused operands, invalid decode
        do_reset();
        cyc(1, 1, LW, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "C_lw0");
        cyc(1, 0, LW, 0, 0, 1, 0, 0, 1, 1,  0, 2'b00, 0, 0, "C_read0");
        cyc(1, 1, LW, 9, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "C_lw9");
        cyc(1, 0, LW, 0, 0, 1, 9, 9, 0, 0,  0, 2'b00, 1, 0, "C_nouse");
        cyc(1, 1, LW, 9, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "C_lw9b");
        cyc(1, 0, LW, 0, 0, 0, 9, 9, 1, 1,  0, 2'b00, 1, 0, "C_decinv");

        // Flush blocks capture and stall but keeps existing slots
        do_reset();
        cyc(3, 1, LW, 4, 1, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "D_flush_issue");
        cyc(3, 0, LW, 0, 0, 1, 4, 0, 1, 0,  0, 2'b00, 0, 0, "D_nocap");
        cyc(3, 1, LW, 6, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "D_issue6");
        cyc(3, 0, LW, 0, 1, 1, 6, 0, 1, 0,  0, 2'b00, 4, 0, "D_flush_stall");
        cyc(3, 0, LW, 0, 0, 1, 6, 0, 1, 0,  1, 2'b01, 2, 0, "D_persist");

        // LOAD_LAT=2 back-to-back loads feeding both operands
        do_reset();
        cyc(2, 1, LW, 2, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "E_lw2");
        cyc(2, 1, LW, 3, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2, 0, "E_lw3");
        cyc(2, 0, LW, 0, 0, 1, 2, 3, 1, 1,  1, 2'b11, 3, 0, "E_both");
        cyc(2, 0, LW, 0, 0, 1, 2, 3, 1, 1,  1, 2'b10, 1, 1, "E_rt");
        cyc(2, 0, LW, 0, 0, 1, 2, 3, 1, 1,  0, 2'b00, 0, 2, "E_done");

        // Asynchronous reset in the middle of a stall
        do_reset();
        cyc(3, 1, LW, 7, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "F_issue");
        cyc(3, 0, LW, 0, 0, 1, 0, 7, 0, 1,  1, 2'b10, 4, 0, "F_s1");
        set_in(0, LW, 0, 0, 1, 0, 7, 0, 1);
        push(3, 1, 2'b10, 2, 1, "F_s2");
        @(negedge clk);
        pop_check();
        #2;
        reset = 1'b0;
        #1;
        push(3, 0, 2'b00, 0, 0, "F_async_rst");
        pop_check();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // CNT_W=4 counter saturation over 20 stalled cycles
        do_reset();
        cyc(4, 1, LW, 8, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 0, "G_first");
        for (int i = 0; i < 20; i++)
            cyc(4, 1, LW, 8, 0, 1, 8, 0, 1, 0, 1, 2'b01, 1,
                16'((i < 15) ? i : 15), "G_sat");
        cyc(4, 0, LW, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 1, 15, "G_hold");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
